dac_cmd_scheduler: RTL and testbench

Arbitrates ultrasonic DAC commands from three requesters (0 = PS/safety, 1 = host UART, 2 = local panel). Drives the control inputs of the DAC sending unit. Large INC/DEC amounts are split into rate-limited steps of at most MAX_STEP, separated by GAP_CYCLES. Issuing stalls while the downstream order FIFO reports full.

---
 rtl/dac_cmd_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_dac_cmd_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_cmd_scheduler.sv
// rtl/dac_cmd_scheduler.sv - arbitrates DAC commands from three requesters and splits INC/DEC into rate-limited steps
// Optional level shadow and step clamping: define SCHED_LEVEL_TRACK_EN.
module dac_cmd_scheduler #(
  parameter int MAX_STEP   = 16,
  parameter int GAP_CYCLES = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req_valid,
  output logic [2:0]  req_ready,
  input  logic [5:0]  req_op,
  input  logic [23:0] req_amount,
  input  logic        order_full,
  output logic        send_enable,
  output logic        valid_o,
  output logic [7:0]  amount_o,
  output logic        increase_o,
  output logic        decrease_o,
  output logic        on_o,
  output logic        off_o,
  output logic [1:0]  grant_id,
  output logic        busy
`ifdef SCHED_LEVEL_TRACK_EN
  ,
  output logic [11:0] level_o
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  localparam logic [1:0] OP_ON  = 2'b00;
  localparam logic [1:0] OP_INC = 2'b01;
  localparam logic [1:0] OP_DEC = 2'b10;
  localparam logic [1:0] OP_OFF = 2'b11;
  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [7:0] MAX_B = 8'(MAX_STEP);

  state_t          state, state_n;
  logic [1:0]      op_q, op_n;
  logic [7:0]      rem_q, rem_n;
  logic [1:0]      grant_q, grant_n;
  logic [1:0]      rr_q, rr_n;
  logic            dac_q, dac_n;
  logic [GW-1:0]   gap_q, gap_n;
  logic            win_vld;
  logic [1:0]      win;
  logic [1:0]      win_op;
  logic [7:0]      win_amt;
  logic            preempt;
  logic [7:0]      step;
`ifdef SCHED_LEVEL_TRACK_EN
  logic [11:0]     level_q, level_n;
  logic [7:0]      room;
`endif

  always_comb begin
    win_vld = |req_valid;
    win     = 2'd0;
    win_op  = req_op[1:0];
    win_amt = req_amount[7:0];
    if (req_valid[0])                      win = 2'd0;
    else if (req_valid[1] && req_valid[2]) win = rr_q;
    else if (req_valid[1])                 win = 2'd1;
    else if (req_valid[2])                 win = 2'd2;
    case (win)
      2'd1:    begin win_op = req_op[3:2]; win_amt = req_amount[15:8];  end
      2'd2:    begin win_op = req_op[5:4]; win_amt = req_amount[23:16]; end
      default: begin win_op = req_op[1:0]; win_amt = req_amount[7:0];   end
    endcase
  end

  // Only a safety OFF may interrupt a command owned by the host or panel.
  assign preempt = (state != IDLE) && (grant_q == 2'd1 || grant_q == 2'd2) &&
                   req_valid[0] && (req_op[1:0] == OP_OFF);

  always_comb begin
    step = (rem_q < MAX_B) ? rem_q : MAX_B;
`ifdef SCHED_LEVEL_TRACK_EN
    room = (op_q == OP_INC) ? 8'((12'd4095 - level_q) >> 4) : 8'(level_q >> 4);
    if (room < step) step = room;
`endif
  end

  always_comb begin
    state_n     = state;
    op_n        = op_q;
    rem_n       = rem_q;
    grant_n     = grant_q;
    rr_n        = rr_q;
    dac_n       = dac_q;
    gap_n       = gap_q;
    req_ready   = 3'b000;
    send_enable = dac_q;
    valid_o     = dac_q;
    on_o        = dac_q;
    amount_o    = 8'd0;
    increase_o  = 1'b0;
    decrease_o  = 1'b0;
    off_o       = 1'b0;
`ifdef SCHED_LEVEL_TRACK_EN
    level_n     = level_q;
`endif
    if (preempt) begin
      req_ready = 3'b001;
      state_n   = ISSUE;
      op_n      = OP_OFF;
      rem_n     = 8'd0;
      grant_n   = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            req_ready = 3'b001 << win;
            if (win != 2'd0) rr_n = (win == 2'd1) ? 2'd2 : 2'd1;
            // ON and zero-amount steps only raise the level hold, no pulse.
            if (win_op == OP_ON || (win_op != OP_OFF && win_amt == 8'd0)) begin
              dac_n = 1'b1;
            end else begin
              state_n = ISSUE;
              op_n    = win_op;
              rem_n   = win_amt;
              grant_n = win;
            end
          end
        end
        ISSUE: begin
          if (!order_full) begin
            if (op_q == OP_OFF) begin
              send_enable = 1'b1;
              valid_o     = 1'b1;
              on_o        = 1'b0;
              off_o       = 1'b1;
              dac_n       = 1'b0;
              state_n     = IDLE;
              grant_n     = 2'd3;
`ifdef SCHED_LEVEL_TRACK_EN
              level_n     = 12'd0;
`endif
            end else if (step == 8'd0) begin
              state_n = IDLE;
              grant_n = 2'd3;
            end else begin
              send_enable = 1'b1;
              valid_o     = 1'b1;
              on_o        = 1'b1;
              amount_o    = step;
              increase_o  = (op_q == OP_INC);
              decrease_o  = (op_q == OP_DEC);
              rem_n       = rem_q - step;
              dac_n       = 1'b1;
`ifdef SCHED_LEVEL_TRACK_EN
              level_n = (op_q == OP_INC) ? level_q + {step, 4'b0000}
                                         : level_q - {step, 4'b0000};
`endif
              if (rem_q == step) begin
                state_n = IDLE;
                grant_n = 2'd3;
              end else begin
                state_n = GAP;
                gap_n   = GAP_LOAD;
              end
            end
          end
        end
        GAP: begin
          if (gap_q <= GW'(1)) state_n = ISSUE;
          else                 gap_n   = gap_q - GW'(1);
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= OP_ON;
      rem_q   <= 8'd0;
      grant_q <= 2'd3;
      rr_q    <= 2'd1;
      dac_q   <= 1'b0;
      gap_q   <= '0;
`ifdef SCHED_LEVEL_TRACK_EN
      level_q <= 12'd0;
`endif
    end else begin
      state   <= state_n;
      op_q    <= op_n;
      rem_q   <= rem_n;
      grant_q <= grant_n;
      rr_q    <= rr_n;
      dac_q   <= dac_n;
      gap_q   <= gap_n;
`ifdef SCHED_LEVEL_TRACK_EN
      level_q <= level_n;
`endif
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state != IDLE);
`ifdef SCHED_LEVEL_TRACK_EN
  assign level_o  = level_q;
`endif

endmodule

// File: tb/tb_dac_cmd_scheduler.sv
// tb/tb_dac_cmd_scheduler.sv - directed self-checking bench for dac_cmd_scheduler
module tb_dac_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [5:0]  req_op;
  logic [23:0] req_amount;
  logic        order_full;
  logic        send_enable, valid_o, increase_o, decrease_o, on_o, off_o, busy;
  logic [7:0]  amount_o;
  logic [1:0]  grant_id;
`ifdef SCHED_LEVEL_TRACK_EN
  logic [11:0] level_o;
`endif

  int checks = 0;
  int errors = 0;
  int np, on_low, on_high, both_cnt;
  int pcyc[16];
  int pamt[16];
  int pkind[16];

  dac_cmd_scheduler #(.MAX_STEP(16), .GAP_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_amount(req_amount), .order_full(order_full),
    .send_enable(send_enable), .valid_o(valid_o), .amount_o(amount_o),
    .increase_o(increase_o), .decrease_o(decrease_o), .on_o(on_o), .off_o(off_o),
    .grant_id(grant_id), .busy(busy)
`ifdef SCHED_LEVEL_TRACK_EN
    , .level_o(level_o)
`endif
  );

  always #5 clk = ~clk;

  task apply_reset;
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_amount = '0; order_full = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task send(input int id, input logic [1:0] op, input logic [7:0] amt, input logic [2:0] exp_ready);
    @(posedge clk); #2;
    req_valid[id] = 1'b1; req_op[2*id +: 2] = op; req_amount[8*id +: 8] = amt;
    @(negedge clk);
    checks++;
    if (req_ready !== exp_ready) begin
      errors++; $display("FAIL send_ready id=%0d got %b want %b", id, req_ready, exp_ready);
    end
    @(posedge clk); #2;
    req_valid = '0;
  endtask

  task collect(input int n);
    np = 0; on_low = 0; on_high = 0; both_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (increase_o && decrease_o) both_cnt++;
      if (on_o) on_high++; else on_low++;
      if ((increase_o || decrease_o || off_o) && np < 16) begin
        pcyc[np] = i; pamt[np] = amount_o;
        pkind[np] = increase_o ? 1 : (decrease_o ? 2 : 3);
        np++;
      end
    end
  endtask

  task test_reset;
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_amount = '0; order_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({send_enable, valid_o, on_o, off_o, increase_o, decrease_o, busy} !== 7'b0 ||
        amount_o !== 8'd0 || grant_id !== 2'd3 || req_ready !== 3'b000) begin
      errors++; $display("FAIL reset_outputs got ctl=%b amt=%0d gid=%0d want 0/0/3",
        {send_enable, valid_o, on_o, off_o, increase_o, decrease_o, busy}, amount_o, grant_id);
    end
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  task test_inc_split;
    send(1, 2'b00, 8'd0, 3'b010);
    @(negedge clk);
    checks++;
    if (on_o !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL on_level got on=%b busy=%b want 1 0", on_o, busy);
    end
    send(1, 2'b01, 8'd40, 3'b010);
    collect(12);
    checks++;
    if (np !== 3) begin errors++; $display("FAIL split_count got %0d want 3", np); end
    checks++;
    if (pcyc[0] !== 0 || pcyc[1] !== 4 || pcyc[2] !== 8) begin
      errors++; $display("FAIL split_spacing got %0d %0d %0d want 0 4 8", pcyc[0], pcyc[1], pcyc[2]);
    end
    checks++;
    if (pamt[0] !== 16 || pamt[1] !== 16 || pamt[2] !== 8) begin
      errors++; $display("FAIL split_amounts got %0d %0d %0d want 16 16 8", pamt[0], pamt[1], pamt[2]);
    end
    checks++;
    if (pkind[0] !== 1 || pkind[1] !== 1 || pkind[2] !== 1 || both_cnt !== 0) begin
      errors++; $display("FAIL split_kind got %0d %0d %0d both=%0d want inc", pkind[0], pkind[1], pkind[2], both_cnt);
    end
    checks++;
    if (on_low !== 0) begin errors++; $display("FAIL split_on_hold got %0d low cycles want 0", on_low); end
    checks++;
    if (busy !== 1'b0 || grant_id !== 2'd3) begin
      errors++; $display("FAIL split_end got busy=%b gid=%0d want 0 3", busy, grant_id);
    end
  endtask

  task test_back_to_back;
    logic [2:0] exp_ready;
    int exp_id;
    bit found;
    apply_reset;
    @(posedge clk); #2;
    req_valid = 3'b110; req_op = 6'b01_01_00; req_amount = {8'd5, 8'd5, 8'd0};
    for (int k = 0; k < 4; k++) begin
      exp_id = (k % 2 == 0) ? 1 : 2;
      exp_ready = 3'b001 << exp_id;
      found = 1'b0;
      for (int t = 0; t < 8 && !found; t++) begin
        @(negedge clk);
        if (req_ready !== 3'b000) found = 1'b1;
      end
      checks++;
      if (!found || req_ready !== exp_ready) begin
        errors++; $display("FAIL rr_ready k=%0d got %b want %b", k, req_ready, exp_ready);
      end
      @(negedge clk);
      checks++;
      if (grant_id !== exp_id[1:0] || increase_o !== 1'b1 || amount_o !== 8'd5) begin
        errors++; $display("FAIL rr_pulse k=%0d got gid=%0d inc=%b amt=%0d want %0d 1 5",
          k, grant_id, increase_o, amount_o, exp_id);
      end
    end
    @(posedge clk); #2 req_valid = '0;
  endtask

  task test_preempt;
    send(2, 2'b01, 8'd100, 3'b100);
    @(negedge clk);
    checks++;
    if (increase_o !== 1'b1 || amount_o !== 8'd16) begin
      errors++; $display("FAIL pre_first got inc=%b amt=%0d want 1 16", increase_o, amount_o);
    end
    @(posedge clk); #2;
    req_valid[0] = 1'b1; req_op[1:0] = 2'b11;
    @(negedge clk);
    checks++;
    if (req_ready !== 3'b001 || busy !== 1'b1) begin
      errors++; $display("FAIL pre_accept got ready=%b busy=%b want 001 1", req_ready, busy);
    end
    @(posedge clk); #2 req_valid = '0;
    collect(6);
    checks++;
    if (np !== 1 || pkind[0] !== 3 || pcyc[0] !== 0 || pamt[0] !== 0) begin
      errors++; $display("FAIL pre_off got n=%0d kind=%0d cyc=%0d amt=%0d want 1 3 0 0", np, pkind[0], pcyc[0], pamt[0]);
    end
    checks++;
    if (on_high !== 0 || busy !== 1'b0 || grant_id !== 2'd3) begin
      errors++; $display("FAIL pre_after got on_cycles=%0d busy=%b gid=%0d want 0 0 3", on_high, busy, grant_id);
    end
  endtask

  task test_order_full;
    order_full = 1'b1;
    send(1, 2'b01, 8'd20, 3'b010);
    collect(10);
    checks++;
    if (np !== 0 || busy !== 1'b1) begin
      errors++; $display("FAIL full_stall got pulses=%0d busy=%b want 0 1", np, busy);
    end
    @(posedge clk); #2 order_full = 1'b0;
    collect(6);
    checks++;
    if (np !== 2 || pcyc[0] !== 0 || pamt[0] !== 16 || pcyc[1] !== 4 || pamt[1] !== 4) begin
      errors++; $display("FAIL full_release got n=%0d c0=%0d a0=%0d c1=%0d a1=%0d want 2 0 16 4 4",
        np, pcyc[0], pamt[0], pcyc[1], pamt[1]);
    end
  endtask

  task test_zero_and_reset;
    apply_reset;
    send(1, 2'b01, 8'd0, 3'b010);
    collect(3);
    checks++;
    if (np !== 0 || on_low !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_inc got pulses=%0d on_low=%0d busy=%b want 0 0 0", np, on_low, busy);
    end
    send(1, 2'b10, 8'd40, 3'b010);
    collect(2);
    checks++;
    if (np !== 1 || pkind[0] !== 2 || pamt[0] !== 16) begin
      errors++; $display("FAIL dec_first got n=%0d kind=%0d amt=%0d want 1 2 16", np, pkind[0], pamt[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({send_enable, valid_o, on_o, off_o, increase_o, decrease_o, busy} !== 7'b0 ||
        amount_o !== 8'd0 || grant_id !== 2'd3) begin
      errors++; $display("FAIL mid_reset got ctl=%b amt=%0d gid=%0d want 0/0/3",
        {send_enable, valid_o, on_o, off_o, increase_o, decrease_o, busy}, amount_o, grant_id);
    end
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

`ifdef SCHED_LEVEL_TRACK_EN
  task test_level_track;
    apply_reset;
    send(1, 2'b01, 8'd250, 3'b010);
    collect(70);
    checks++;
    if (level_o !== 12'd4000 || busy !== 1'b0) begin
      errors++; $display("FAIL level_fill got %0d busy=%b want 4000 0", level_o, busy);
    end
    send(1, 2'b01, 8'd16, 3'b010);
    collect(10);
    checks++;
    if (np !== 1 || pamt[0] !== 5 || level_o !== 12'd4080 || busy !== 1'b0) begin
      errors++; $display("FAIL level_clamp got n=%0d amt=%0d level=%0d busy=%b want 1 5 4080 0",
        np, pamt[0], level_o, busy);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_inc_split;
    test_back_to_back;
    test_preempt;
    test_order_full;
    test_zero_and_reset;
`ifdef SCHED_LEVEL_TRACK_EN
    test_level_track;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
